uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte buffer and launch controller that sits directly upstream of uart_tx. Producers push bytes at core-clock rate. The block drains them one at a time into uart_tx using its level start/tx_busy handshake. This lets software or a loopback path queue a burst of bytes without waiting out each 9600-baud frame.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
DATA_W, 8, byte width; must match uart_tx data width

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
wr_en  input  1  push request, single-cycle qualified
wr_data  input  DATA_W  byte to push
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  $clog2(DEPTH)+1  entries currently stored (not including the byte in tx_data)
tx_data  output  DATA_W  byte presented to uart_tx data
tx_start  output  1  to uart_tx start
tx_busy  input  1  from uart_tx tx_busy
overflow  output  1  one-cycle pulse, push dropped
drop_count  output  8  saturating dropped-byte counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). All state is registered on posedge clk.
- Reset values:
  - Pointers and count: 0, so empty=1 and full=0.
  - tx_data=0, tx_start=0, overflow=0, drop_count=0.
  - FSM returns to IDLE.
- Reset mid-operation:
  - Queued bytes are discarded and tx_start drops the next cycle.
  - A frame already inside uart_tx is not aborted by this block.
- Storage:
  - Circular buffer with $clog2(DEPTH)-bit read and write pointers that wrap naturally from DEPTH-1 to 0.
  - Separate count register.
- Push:
  - wr_en & ~full: write wr_data at wr_ptr, then wr_ptr+1.
  - wr_en & full: byte dropped, no state change, overflow=1 the next cycle.
  - full is evaluated on the pre-edge count. A push while full is dropped even if a pop happens in the same cycle.
- Pop: happens only in IDLE when ~empty & ~tx_busy.
  - tx_data <= mem[rd_ptr]; rd_ptr+1.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged.
- Launch FSM:
  - IDLE: if ~empty & ~tx_busy, pop, set tx_start<=1 and go to START. Otherwise stay.
  - START: hold tx_start=1 and tx_data stable. When tx_busy==1 is sampled, set tx_start<=0 and go to BUSY. There is no timeout.
  - BUSY: hold tx_data. When tx_busy==0, go to IDLE.
- Latency:
  - A byte accepted at edge N into an empty FIFO, with tx_busy=0, gives tx_start=1 in the cycle after edge N+1.
  - Between frames, at least one IDLE cycle separates tx_busy falling from the next tx_start rising.
- tx_data changes only on a pop. It is held through START and BUSY.
- A tx_busy that is already high in IDLE (for example after reset) blocks launch until it falls.

Optional Feature:
Macro UART_TX_FIFO_DROP_CNT_EN.
- Defined: drop_count increments by 1 on every dropped push and saturates at 8'hFF. It is cleared only by rst.
- Undefined: drop_count is tied to 8'h00 and the counter logic is absent. The overflow pulse is unaffected either way.

Test Plan:
- Reset, then push 0x55 once with tx_busy model idle:
  - tx_start high 2 cycles after the push cycle, with tx_data=0x55.
  - tx_start drops the cycle after tx_busy rises.
  - count returns to 0.
- Burst push 0x01..0x05 back-to-back against a uart_tx model whose busy lasts 20 cycles:
  - Five frames are launched in order 0x01..0x05.
  - No tx_start while tx_busy=1.
  - empty=1 at the end.
- Push 17 bytes with tx_busy forced high (DEPTH=16):
  - full=1 after 16 pushes.
  - The 17th push gives a one-cycle overflow pulse.
  - drop_count=1 with the macro defined, 0 without.
- Pointer wrap: repeatedly push and drain 40 bytes with values 0x00..0x27:
  - Output order matches exactly across two wraps.
  - count never exceeds 16.
- Simultaneous push and pop when count=3:
  - count stays 3.
  - With full (count=16), a simultaneous push is dropped and count becomes 15.
- Assert rst while in START with 4 bytes queued:
  - Next cycle: tx_start=0, count=0, empty=1, tx_data=0.
  - No launch occurs until a new push.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte queue plus launch controller placed directly in front of uart_tx.
// Producers push bytes at core-clock rate; the block hands them one at a
// time to uart_tx through its level start / tx_busy handshake. This lets a
// burst of bytes be queued without waiting out each serial frame.
//
// Handshake with uart_tx:
//   tx_start is a level request. It rises one cycle after a pop, stays high
//   (with tx_data stable) until tx_busy is sampled high, then drops. The next
//   pop waits for tx_busy to be sampled low and at least one IDLE cycle.
//   Nothing here aborts a frame that uart_tx has already started.
//
// Parameters:
//   DEPTH  - FIFO entries (power of two, >= 2)
//   DATA_W - byte width (must match uart_tx)
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   wr_en, wr_data  - single-cycle push request and its byte
//   full, empty     - occupancy flags (count == DEPTH / count == 0)
//   count           - bytes stored, excluding the one held in tx_data
//   tx_data         - byte presented to uart_tx
//   tx_start        - start request to uart_tx
//   tx_busy         - busy indication from uart_tx
//   overflow        - one-cycle pulse after a push was dropped while full
//   drop_count      - saturating count of dropped pushes
//
// Optional feature (macro UART_TX_FIFO_DROP_CNT_EN):
//   defined   - drop_count counts dropped pushes, saturating at 8'hFF,
//               cleared only by rst
//   undefined - drop_count is tied to 8'h00 and no counter is built
//
// The launch FSM state is held in state_q for checker binding.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic full_w;
  logic empty_w;
  logic push;
  logic pop;

  // Flags come from the pre-edge count, so a push while full is dropped
  // even when a pop frees a slot in the same cycle.
  assign full_w  = (count_q == CNT_MAX);
  assign empty_w = (count_q == '0);
  assign push    = wr_en & ~full_w;

  // Push/pop can never hit the same slot: a pop needs ~empty, and with
  // ~empty & ~full the two pointers differ.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Launch FSM and datapath next-state.
  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty_w && !tx_busy) begin
          pop        = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    overflow_d = wr_en & full_w;
    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef UART_TX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= 8'h00;
    end else if (wr_en && full_w && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'h01;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 8'h00;
`endif

  assign full     = full_w;
  assign empty    = empty_w;
  assign count    = count_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo (DEPTH=16, DATA_W=8). A small uart_tx
// stand-in raises tx_busy for busy_len cycles per accepted start; a launch
// monitor compares every launched byte against the expected queue.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;

`ifdef UART_TX_FIFO_DROP_CNT_EN
  localparam int DROP_ON = 1;
`else
  localparam int DROP_ON = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_en;
  logic [DATA_W-1:0]     wr_data;
  logic                  full;
  logic                  empty;
  logic [$clog2(DEPTH):0] count;
  logic [DATA_W-1:0]     tx_data;
  logic                  tx_start;
  logic                  tx_busy;
  logic                  overflow;
  logic [7:0]            drop_count;

  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  int   model_cnt  = 0;
  int   busy_len   = 20;

  assign tx_busy = force_busy | model_busy;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  // ---------------- scoreboard state ----------------
  int              vectors     = 0;
  int              miscompares = 0;
  int              launches    = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic            prev_start  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // uart_tx stand-in: accepts a start when idle, stays busy busy_len cycles.
  always @(posedge clk) begin
    if (model_busy) begin
      if (model_cnt <= 1) model_busy <= 1'b0;
      else                model_cnt  <= model_cnt - 1;
    end else if (tx_start === 1'b1) begin
      model_busy <= 1'b1;
      model_cnt  <= busy_len;
    end
  end

  // Launch monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (tx_start === 1'b1 && prev_start === 1'b0) begin
      launches++;
      check("launch_while_busy", 32'(tx_busy), 32'd0);
      check("launch_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("launch_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    check("count_bound", 32'(count <= 5'(DEPTH)), 32'd1);
    prev_start = tx_start;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int   n    = 0;
    logic done = 1'b0;
    while (!done && n < budget) begin
      done = (exp_q.size() == 0) && (tx_busy === 1'b0) &&
             (tx_start === 1'b0) && (empty === 1'b1);
      if (!done) begin
        tick();
        n++;
      end
    end
    check("drain_done", 32'(done), 32'd1);
    tick();
    tick();
  endtask

  // Watchdog: never let the run hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int l0;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    tick();
    tick();

    // Reset state
    check("rst_count",    32'(count),      32'd0);
    check("rst_empty",    32'(empty),      32'd1);
    check("rst_full",     32'(full),       32'd0);
    check("rst_tx_start", 32'(tx_start),   32'd0);
    check("rst_tx_data",  32'(tx_data),    32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    check("rst_drop",     32'(drop_count), 32'd0);
    rst = 1'b0;

    // Single byte latency and handshake
    wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
    tick();
    wr_en = 1'b0;
    check("t1_count_after_push", 32'(count),    32'd1);
    check("t1_start_not_yet",    32'(tx_start), 32'd0);
    tick();
    check("t1_start_high",       32'(tx_start), 32'd1);
    check("t1_tx_data",          32'(tx_data),  32'h55);
    check("t1_count_after_pop",  32'(count),    32'd0);
    tick();
    check("t1_busy_seen",        32'(tx_busy),  32'd1);
    check("t1_start_held",       32'(tx_start), 32'd1);
    tick();
    check("t1_start_dropped",    32'(tx_start), 32'd0);
    check("t1_data_held",        32'(tx_data),  32'h55);
    drain(100);
    check("t1_count_final",      32'(count),    32'd0);

    // Burst of five against a 20-cycle busy
    l0 = launches;
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i));
      tick();
    end
    wr_en = 1'b0;
    drain(400);
    check("t2_launches", 32'(launches - l0), 32'd5);
    check("t2_empty",    32'(empty),         32'd1);

    // Fill to full with busy forced high, then one more push
    busy_len   = 4;
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'hA0 + 8'(i); exp_q.push_back(8'hA0 + 8'(i));
      tick();
    end
    check("t3_full",          32'(full),     32'd1);
    check("t3_count16",       32'(count),    32'd16);
    check("t3_no_launch",     32'(tx_start), 32'd0);
    check("t3_no_ovf_yet",    32'(overflow), 32'd0);
    wr_data = 8'hB0;
    tick();
    wr_en = 1'b0;
    check("t3_overflow",      32'(overflow),   32'd1);
    check("t3_count_kept",    32'(count),      32'd16);
    check("t3_drop_count",    32'(drop_count), 32'(DROP_ON));
    tick();
    check("t3_overflow_off",  32'(overflow),   32'd0);

    // Push while full in the same cycle as a pop: push dropped
    wr_en = 1'b1; wr_data = 8'hEE; force_busy = 1'b0;
    tick();
    wr_en = 1'b0;
    check("t3_full_pop_count", 32'(count),      32'd15);
    check("t3_full_pop_ovf",   32'(overflow),   32'd1);
    check("t3_full_pop_start", 32'(tx_start),   32'd1);
    check("t3_full_pop_data",  32'(tx_data),    32'hA0);
    check("t3_drop_count2",    32'(drop_count), 32'(2 * DROP_ON));
    drain(1000);
    check("t3_empty", 32'(empty), 32'd1);

    // Simultaneous push and pop at count 3, then reset while in START
    force_busy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i); exp_q.push_back(8'h30 + 8'(i));
      tick();
    end
    wr_en = 1'b0;
    check("t4_count3", 32'(count), 32'd3);
    wr_en = 1'b1; wr_data = 8'h34; exp_q.push_back(8'h34); force_busy = 1'b0;
    tick();
    check("t4_pushpop_count", 32'(count),    32'd3);
    check("t4_pushpop_start", 32'(tx_start), 32'd1);
    check("t4_pushpop_data",  32'(tx_data),  32'h31);
    wr_data = 8'h35; exp_q.push_back(8'h35);
    tick();
    wr_en = 1'b0;
    check("t4_count4",       32'(count),    32'd4);
    check("t4_still_start",  32'(tx_start), 32'd1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    check("t5_rst_start",    32'(tx_start),   32'd0);
    check("t5_rst_count",    32'(count),      32'd0);
    check("t5_rst_empty",    32'(empty),      32'd1);
    check("t5_rst_tx_data",  32'(tx_data),    32'd0);
    check("t5_rst_drop",     32'(drop_count), 32'd0);
    rst = 1'b0;
    l0 = launches;
    repeat (40) tick();
    check("t5_no_launch",    32'(launches - l0), 32'd0);
    check("t5_start_low",    32'(tx_start),      32'd0);
    check("t5_still_empty",  32'(empty),         32'd1);

    // Pointer wrap: 40 bytes in chunks of 8
    busy_len = 3;
    l0 = launches;
    for (int c = 0; c < 5; c++) begin
      for (int j = 0; j < 8; j++) begin
        wr_en = 1'b1; wr_data = 8'(c * 8 + j); exp_q.push_back(8'(c * 8 + j));
        tick();
      end
      wr_en = 1'b0;
      drain(300);
    end
    check("t6_launches", 32'(launches - l0), 32'd40);
    check("t6_empty",    32'(empty),         32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
